// File: rtl/mio_pkg.sv
// Shared definitions for the MIO bus responder: FSM encoding, target
// selects, the peripheral address map and the default wait-state count.
package mio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_DONE,
    ST_GAP
  } state_e;

  typedef enum logic [2:0] {
    TGT_RAM,
    TGT_LED,
    TGT_SW,
    TGT_CNT,
    TGT_NONE
  } tgt_e;

  localparam int          WAIT_CYCLES_DEFAULT = 1;
  localparam logic [3:0]  PERIPH_REGION       = 4'hF;
  localparam logic [31:0] ADDR_LED            = 32'hF000_0000;
  localparam logic [31:0] ADDR_SW             = 32'hF000_0004;
  localparam logic [31:0] ADDR_CNT            = 32'hFC00_0000;

  // Word-granular compare; byte-offset bits never take part in decode.
  function automatic logic word_match(input logic [29:0] word_addr,
                                      input logic [29:0] word_base);
    return word_addr == word_base;
  endfunction

endpackage

// File: rtl/mio_addr_decode.sv
// Combinational address decoder: maps a CPU byte address onto the target
// it selects. Everything outside the 0xF region is RAM; unmapped 0xF
// addresses select NONE so they read zero and swallow writes.
module mio_addr_decode
  import mio_pkg::*;
(
  input  logic [31:0] addr,
  output logic [2:0]  tgt
);

  // Byte-offset bits are intentionally ignored by the decoder.
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^addr[1:0];

  // Region check first, then exact word matches inside the peripheral region.
  always_comb begin
    tgt = TGT_NONE;
    if (addr[31:28] != PERIPH_REGION) begin
      tgt = TGT_RAM;
    end else if (word_match(addr[31:2], ADDR_LED[31:2])) begin
      tgt = TGT_LED;
    end else if (word_match(addr[31:2], ADDR_SW[31:2])) begin
      tgt = TGT_SW;
    end else if (word_match(addr[31:2], ADDR_CNT[31:2])) begin
      tgt = TGT_CNT;
    end
  end

endmodule

// File: rtl/mio_bus_responder.sv
// CPU-side memory/IO responder. A request sampled in IDLE is latched, then
// walks WAIT (optional) -> ACCESS -> DONE -> GAP. RAM read data comes back
// from the synchronous RAM during DONE and is steered straight to Data_out
// for that cycle, then captured so Data_out holds it afterwards.
module mio_bus_responder
  import mio_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CPU_MIO,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr_in,
  input  logic [31:0] Data_in,
  input  logic [15:0] SW_in,
  input  logic [31:0] ram_rdata,
  output logic [31:0] Data_out,
  output logic        MIO_ready,
  output logic        ram_en,
  output logic        ram_we,
  output logic [9:0]  ram_addr,
  output logic [31:0] ram_wdata,
  output logic [31:0] LED_out,
  output logic        bus_err
);

  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e      state_reg;
  tgt_e        tgt_reg;
  logic        wr_reg;
  logic [3:0]  wait_cnt_reg;
  logic        rd_ram_reg;
  logic        mio_ready_reg;
  logic        ram_en_reg;
  logic        ram_we_reg;
  logic        bus_err_reg;
  logic [9:0]  ram_addr_reg;
  logic [31:0] ram_wdata_reg;
  logic [31:0] data_out_reg;
  logic [31:0] led_reg;
  logic [31:0] cnt_reg;

  logic [2:0]  dec_tgt;
  tgt_e        dec_tgt_e;
  logic        req_valid;
  logic        req_both;

  mio_addr_decode u_decode (
    .addr (Addr_in),
    .tgt  (dec_tgt)
  );

  assign dec_tgt_e = tgt_e'(dec_tgt);
  assign req_valid = CPU_MIO && (MemRead ^ MemWrite);
  assign req_both  = CPU_MIO && MemRead && MemWrite;

  // Free-running cycle counter, readable at ADDR_CNT.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= 32'd0;
    end else begin
      cnt_reg <= cnt_reg + 32'd1;
    end
  end

  // Transaction FSM with all bus-facing outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      tgt_reg       <= TGT_NONE;
      wr_reg        <= 1'b0;
      wait_cnt_reg  <= 4'd0;
      rd_ram_reg    <= 1'b0;
      mio_ready_reg <= 1'b0;
      ram_en_reg    <= 1'b0;
      ram_we_reg    <= 1'b0;
      bus_err_reg   <= 1'b0;
      ram_addr_reg  <= 10'd0;
      ram_wdata_reg <= 32'd0;
      data_out_reg  <= 32'd0;
      led_reg       <= 32'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_both) begin
            bus_err_reg <= 1'b1;
          end else if (req_valid) begin
            tgt_reg       <= dec_tgt_e;
            wr_reg        <= MemWrite;
            ram_addr_reg  <= Addr_in[11:2];
            ram_wdata_reg <= Data_in;
            wait_cnt_reg  <= 4'd0;
            if (WAIT_CYCLES > 0) begin
              state_reg <= ST_WAIT;
            end else begin
              state_reg  <= ST_ACCESS;
              ram_en_reg <= (dec_tgt_e == TGT_RAM);
              ram_we_reg <= (dec_tgt_e == TGT_RAM) && MemWrite;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt_reg == WAIT_LAST) begin
            state_reg  <= ST_ACCESS;
            ram_en_reg <= (tgt_reg == TGT_RAM);
            ram_we_reg <= (tgt_reg == TGT_RAM) && wr_reg;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 4'd1;
          end
        end
        ST_ACCESS: begin
          ram_en_reg    <= 1'b0;
          ram_we_reg    <= 1'b0;
          mio_ready_reg <= 1'b1;
          rd_ram_reg    <= !wr_reg && (tgt_reg == TGT_RAM);
          state_reg     <= ST_DONE;
          if (wr_reg) begin
            // Only the LED register is writable; other peripheral writes vanish.
            if (tgt_reg == TGT_LED) begin
              led_reg <= ram_wdata_reg;
            end
          end else begin
            case (tgt_reg)
              TGT_LED:  data_out_reg <= led_reg;
              TGT_SW:   data_out_reg <= {16'h0000, SW_in};
              TGT_CNT:  data_out_reg <= cnt_reg;
              TGT_NONE: data_out_reg <= 32'd0;
              default:  ;
            endcase
          end
        end
        ST_DONE: begin
          mio_ready_reg <= 1'b0;
          rd_ram_reg    <= 1'b0;
          if (rd_ram_reg) begin
            data_out_reg <= ram_rdata;
          end
          state_reg <= ST_GAP;
        end
        ST_GAP: begin
          // One dead cycle so a request still held after completion is not re-run.
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign Data_out  = rd_ram_reg ? ram_rdata : data_out_reg;
  assign MIO_ready = mio_ready_reg;
  assign ram_en    = ram_en_reg;
  assign ram_we    = ram_we_reg;
  assign ram_addr  = ram_addr_reg;
  assign ram_wdata = ram_wdata_reg;
  assign LED_out   = led_reg;
  assign bus_err   = bus_err_reg;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Directed bench for mio_bus_responder (WAIT_CYCLES = 1): a vector table of
// single transactions plus hand-written sequences for held requests, bus
// errors, counter reads and reset in the middle of a RAM write.
module tb_mio_bus_responder;

  localparam int W = 1;

  logic        clk;
  logic        reset;
  logic        CPU_MIO;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Addr_in;
  logic [31:0] Data_in;
  logic [15:0] SW_in;
  logic [31:0] ram_rdata;
  logic [31:0] Data_out;
  logic        MIO_ready;
  logic        ram_en;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] LED_out;
  logic        bus_err;

  mio_bus_responder #(.WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .CPU_MIO   (CPU_MIO),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Addr_in   (Addr_in),
    .Data_in   (Data_in),
    .SW_in     (SW_in),
    .ram_rdata (ram_rdata),
    .Data_out  (Data_out),
    .MIO_ready (MIO_ready),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .LED_out   (LED_out),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM model: read data appears the cycle after ram_en.
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
      mem[4]    <= 32'hDEAD_BEEF;
      mem[1023] <= 32'hCAFE_F00D;
      ram_rdata <= 32'd0;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  // Reference cycle count, cleared by reset like the DUT counter.
  logic [31:0] model_cnt;
  always @(posedge clk) begin
    if (reset) model_cnt <= 32'd0;
    else       model_cnt <= model_cnt + 32'd1;
  end

  int n_vec;
  int n_miss;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drop_req();
    CPU_MIO  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  // Results of the most recent run_txn.
  int          t_rdy_c;
  int          t_n_rdy;
  int          t_n_en;
  int          t_n_we;
  logic [9:0]  t_acc_addr;
  logic [31:0] t_dout_done;
  logic [31:0] t_dout_gap;
  logic [31:0] t_led_done;
  logic [31:0] t_cnt_access;

  // Issue one request; cycle c is the c-th cycle after the sampling edge,
  // observed at its falling edge. hold = extra cycles the request stays up
  // after the CPU has seen MIO_ready; late_addr != addr changes Addr_in in cycle 1.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int hold, input logic [31:0] late_addr);
    @(negedge clk);
    CPU_MIO  = 1'b1;
    MemRead  = !wr;
    MemWrite = wr;
    Addr_in  = addr;
    Data_in  = wdata;
    t_rdy_c = -1; t_n_rdy = 0; t_n_en = 0; t_n_we = 0;
    t_acc_addr = 10'h0; t_dout_done = 32'hx; t_dout_gap = 32'hx;
    t_led_done = 32'hx; t_cnt_access = 32'hx;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (MIO_ready) begin
        t_n_rdy++;
        if (t_rdy_c < 0) begin
          t_rdy_c     = c;
          t_dout_done = Data_out;
          t_led_done  = LED_out;
        end
      end
      if (ram_en) begin
        t_n_en++;
        t_acc_addr = ram_addr;
      end
      if (ram_we) t_n_we++;
      if (c == W + 1) t_cnt_access = model_cnt;
      if (c == 1 && late_addr != addr) Addr_in = late_addr;
      if (t_rdy_c > 0 && c == t_rdy_c + 1) t_dout_gap = Data_out;
      if (t_rdy_c > 0 && c == t_rdy_c + 1 + hold) drop_req();
    end
    drop_req();
    $display("txn %s addr=%h: ready_cycle=%0d pulses=%0d ram_en=%0d data=%h led=%h",
             wr ? "WR" : "RD", addr, t_rdy_c, t_n_rdy, t_n_en, t_dout_done, t_led_done);
  endtask

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [15:0] sw;
    int          exp_en;
    int          exp_we;
    logic [9:0]  exp_addr;
    logic [31:0] exp_data;
    logic [31:0] exp_led;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  int          n_rdy;
  int          n_en;
  int          n_we;
  logic [31:0] cnt_a;
  logic [31:0] cnt_b;

  initial begin
    n_vec = 0;
    n_miss = 0;
    reset = 1'b1;
    SW_in = 16'h0000;
    Addr_in = 32'd0;
    Data_in = 32'd0;
    drop_req();

    //            name          wr    addr           wdata          sw      en we addr    data           led
    vecs[0]  = '{"ram_rd4",     1'b0, 32'h0000_0010, 32'h0,         16'h0,  1, 0, 10'h004, 32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{"led_wr",      1'b1, 32'hF000_0000, 32'h0000_A5A5, 16'h0,  0, 0, 10'h000, 32'hDEAD_BEEF, 32'h0000_A5A5};
    vecs[2]  = '{"led_rd",      1'b0, 32'hF000_0000, 32'h0,         16'h0,  0, 0, 10'h000, 32'h0000_A5A5, 32'h0000_A5A5};
    vecs[3]  = '{"sw_rd",       1'b0, 32'hF000_0004, 32'h0,         16'h1234, 0, 0, 10'h000, 32'h0000_1234, 32'h0000_A5A5};
    vecs[4]  = '{"sw_wr",       1'b1, 32'hF000_0004, 32'h0000_FFFF, 16'h1234, 0, 0, 10'h000, 32'h0000_1234, 32'h0000_A5A5};
    vecs[5]  = '{"sw_rd2",      1'b0, 32'hF000_0004, 32'h0,         16'h1234, 0, 0, 10'h000, 32'h0000_1234, 32'h0000_A5A5};
    vecs[6]  = '{"ram_wr8",     1'b1, 32'h0000_0020, 32'h1122_3344, 16'h0,  1, 1, 10'h008, 32'h0000_1234, 32'h0000_A5A5};
    vecs[7]  = '{"ram_rd8_lsb", 1'b0, 32'h0000_0023, 32'h0,         16'h0,  1, 0, 10'h008, 32'h1122_3344, 32'h0000_A5A5};
    vecs[8]  = '{"none_rd",     1'b0, 32'hF000_0100, 32'h0,         16'h0,  0, 0, 10'h000, 32'h0,         32'h0000_A5A5};
    vecs[9]  = '{"none_wr",     1'b1, 32'hF000_0100, 32'h0000_0001, 16'h0,  0, 0, 10'h000, 32'h0,         32'h0000_A5A5};
    vecs[10] = '{"led_wr_lsb",  1'b1, 32'hF000_0003, 32'h5A5A_0000, 16'h0,  0, 0, 10'h000, 32'h0,         32'h5A5A_0000};
    vecs[11] = '{"led_rd2",     1'b0, 32'hF000_0000, 32'h0,         16'h0,  0, 0, 10'h000, 32'h5A5A_0000, 32'h5A5A_0000};
    vecs[12] = '{"ram_top",     1'b0, 32'hEFFF_FFFC, 32'h0,         16'h0,  1, 0, 10'h3FF, 32'hCAFE_F00D, 32'h5A5A_0000};
    vecs[13] = '{"cnt_wr",      1'b1, 32'hFC00_0000, 32'h1234_5678, 16'h0,  0, 0, 10'h000, 32'hCAFE_F00D, 32'h5A5A_0000};
    vecs[14] = '{"sw_rd3",      1'b0, 32'hF000_0004, 32'h0,         16'hBEEF, 0, 0, 10'h000, 32'h0000_BEEF, 32'h5A5A_0000};

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_ready",   {31'd0, MIO_ready}, 32'd0);
    check("rst_ram_en",  {31'd0, ram_en},    32'd0);
    check("rst_ram_we",  {31'd0, ram_we},    32'd0);
    check("rst_dout",    Data_out,           32'd0);
    check("rst_led",     LED_out,            32'd0);
    check("rst_bus_err", {31'd0, bus_err},   32'd0);
    reset = 1'b0;

    // Table-driven single transactions.
    for (int v = 0; v < NV; v++) begin
      SW_in = vecs[v].sw;
      run_txn(vecs[v].wr, vecs[v].addr, vecs[v].wdata, 0, vecs[v].addr);
      check({vecs[v].name, "_latency"},  32'(t_rdy_c), 32'(W + 2));
      check({vecs[v].name, "_pulses"},   32'(t_n_rdy), 32'd1);
      check({vecs[v].name, "_ram_en"},   32'(t_n_en),  32'(vecs[v].exp_en));
      check({vecs[v].name, "_ram_we"},   32'(t_n_we),  32'(vecs[v].exp_we));
      if (vecs[v].exp_en != 0)
        check({vecs[v].name, "_ram_addr"}, {22'd0, t_acc_addr}, {22'd0, vecs[v].exp_addr});
      check({vecs[v].name, "_dout"},     t_dout_done, vecs[v].exp_data);
      check({vecs[v].name, "_dout_hold"}, t_dout_gap, vecs[v].exp_data);
      check({vecs[v].name, "_led"},      t_led_done,  vecs[v].exp_led);
    end
    check("bus_err_clean", {31'd0, bus_err}, 32'd0);

    // Counter reads return the count during ACCESS; run_txn spans 9 cycles.
    run_txn(1'b0, 32'hFC00_0000, 32'h0, 0, 32'hFC00_0000);
    cnt_a = t_dout_done;
    check("cnt_rd_a", t_dout_done, t_cnt_access);
    run_txn(1'b0, 32'hFC00_0000, 32'h0, 0, 32'hFC00_0000);
    cnt_b = t_dout_done;
    check("cnt_rd_b", t_dout_done, t_cnt_access);
    check("cnt_delta", cnt_b - cnt_a, 32'd9);

    // Request held through GAP: still exactly one transaction.
    run_txn(1'b0, 32'h0000_0010, 32'h0, 1, 32'h0000_0010);
    check("hold_pulses", 32'(t_n_rdy), 32'd1);
    check("hold_ram_en", 32'(t_n_en),  32'd1);
    check("hold_dout",   t_dout_done,  32'hDEAD_BEEF);
    run_txn(1'b0, 32'hF000_0000, 32'h0, 0, 32'hF000_0000);
    check("after_hold_latency", 32'(t_rdy_c), 32'(W + 2));
    check("after_hold_dout",    t_dout_done,  32'h5A5A_0000);

    // Address changed after the sampling edge is ignored.
    run_txn(1'b0, 32'h0000_0010, 32'h0, 0, 32'h0000_0020);
    check("late_chg_addr", {22'd0, t_acc_addr}, 32'h4);
    check("late_chg_dout", t_dout_done, 32'hDEAD_BEEF);

    // No CPU_MIO: nothing happens.
    @(negedge clk);
    CPU_MIO = 1'b0; MemRead = 1'b1; Addr_in = 32'h0000_0010;
    n_rdy = 0; n_en = 0;
    repeat (5) begin
      @(negedge clk);
      if (MIO_ready) n_rdy++;
      if (ram_en) n_en++;
    end
    drop_req();
    check("nomio_ready",  32'(n_rdy), 32'd0);
    check("nomio_ram_en", 32'(n_en),  32'd0);

    // Read and write together: sticky bus error, no transaction.
    @(negedge clk);
    CPU_MIO = 1'b1; MemRead = 1'b1; MemWrite = 1'b1; Addr_in = 32'h0000_0010;
    n_rdy = 0; n_en = 0;
    repeat (4) begin
      @(negedge clk);
      if (MIO_ready) n_rdy++;
      if (ram_en) n_en++;
    end
    drop_req();
    $display("txn RD+WR addr=00000010: bus_err=%b pulses=%0d", bus_err, n_rdy);
    check("both_bus_err", {31'd0, bus_err}, 32'd1);
    check("both_ready",   32'(n_rdy), 32'd0);
    check("both_ram_en",  32'(n_en),  32'd0);
    run_txn(1'b0, 32'h0000_0010, 32'h0, 0, 32'h0000_0010);
    check("after_err_latency", 32'(t_rdy_c), 32'(W + 2));
    check("after_err_dout",    t_dout_done,  32'hDEAD_BEEF);
    check("bus_err_sticky",    {31'd0, bus_err}, 32'd1);

    // Reset while a RAM write sits in WAIT.
    @(negedge clk);
    CPU_MIO = 1'b1; MemRead = 1'b0; MemWrite = 1'b1;
    Addr_in = 32'h0000_0040; Data_in = 32'h9999_9999;
    n_we = 0; n_rdy = 0;
    @(negedge clk);
    if (ram_we) n_we++;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_ready",   {31'd0, MIO_ready}, 32'd0);
    check("mid_rst_ram_en",  {31'd0, ram_en},    32'd0);
    check("mid_rst_ram_we",  {31'd0, ram_we},    32'd0);
    check("mid_rst_dout",    Data_out,           32'd0);
    check("mid_rst_led",     LED_out,            32'd0);
    check("mid_rst_bus_err", {31'd0, bus_err},   32'd0);
    reset = 1'b0;
    drop_req();
    repeat (6) begin
      @(negedge clk);
      if (ram_we) n_we++;
      if (MIO_ready) n_rdy++;
    end
    $display("txn WR addr=00000040 aborted by reset: ram_we pulses=%0d ready=%0d", n_we, n_rdy);
    check("mid_rst_no_we",    32'(n_we),  32'd0);
    check("mid_rst_no_ready", 32'(n_rdy), 32'd0);
    check("mid_rst_mem16",    mem[16],    32'd0);

    // Counter restarted by reset.
    run_txn(1'b0, 32'hFC00_0000, 32'h0, 0, 32'hFC00_0000);
    check("cnt_after_rst", t_dout_done, t_cnt_access);
    check("cnt_after_rst_small", {31'd0, (t_dout_done < 32'd64)}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
